ddr_dq_seq: RTL

DDR_DQ_SEQ -- requirements
Module: ddr_dq_seq

---
 rtl/ddr_dq_seq.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ddr_dq_seq.sv
// Burst sequencer for one DDR DQ bank: turns a 4-word write or read request into
// two double-data-rate beats with fixed read (CL) and write (WL) latencies.
module ddr_dq_seq #(
   parameter int BANK_WIDTH = 16,
   parameter int CL         = 3,
   parameter int WL         = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_req,
   input  logic [4*BANK_WIDTH-1:0] wr_data,
   output logic                    wr_ack,
   input  logic                    rd_req,
   output logic                    rd_ack,
   output logic                    rd_valid,
   output logic [2*BANK_WIDTH-1:0] rd_data,
   output logic                    busy,
   output logic                    bank_t,
   output logic [BANK_WIDTH-1:0]   bank_d0,
   output logic [BANK_WIDTH-1:0]   bank_d1,
   input  logic [BANK_WIDTH-1:0]   bank_o0,
   input  logic [BANK_WIDTH-1:0]   bank_o1
);

   if (CL < 1 || CL > 15) begin : gClRange
      $error("ddr_dq_seq: CL must be in 1..15");
   end
   if (WL < 1 || WL > 15) begin : gWlRange
      $error("ddr_dq_seq: WL must be in 1..15");
   end

   typedef enum logic [3:0] {
      IDLE,
      WR_WAIT,
      WR_PRE,
      WR_BEAT0,
      WR_BEAT1,
      WR_POST,
      RD_WAIT,
      RD_CAP0,
      RD_CAP1
   } stateT;

   // Remaining wait cycles after the first WAIT cycle, so the counter expires on the last one.
   localparam logic [3:0] CL_LOAD = (CL >= 2) ? 4'(CL - 2) : 4'd0;
   localparam logic [3:0] WL_LOAD = (WL >= 2) ? 4'(WL - 2) : 4'd0;

   stateT                   r_state;
   stateT                   w_nextState;
   logic [3:0]              r_cnt;
   logic [3:0]              w_nextCnt;
   logic                    w_acceptRd;
   logic                    w_acceptWr;
   logic [4*BANK_WIDTH-1:0] r_wrData;
   logic                    r_wrAck;
   logic                    r_rdAck;
   logic                    r_rdValid;
   logic [2*BANK_WIDTH-1:0] r_rdData;
   logic                    r_bankT;
   logic [BANK_WIDTH-1:0]   r_bankD0;
   logic [BANK_WIDTH-1:0]   r_bankD1;

   // State and latency counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
      end
   end

   // Next-state logic; reads take priority over a simultaneous write request.
   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      w_acceptRd  = 1'b0;
      w_acceptWr  = 1'b0;
      case (r_state)
         IDLE: begin
            if (rd_req) begin
               w_acceptRd = 1'b1;
               if (CL == 1) begin
                  w_nextState = RD_CAP0;
               end else begin
                  w_nextState = RD_WAIT;
                  w_nextCnt   = CL_LOAD;
               end
            end else if (wr_req) begin
               w_acceptWr = 1'b1;
               if (WL == 1) begin
                  w_nextState = WR_PRE;
               end else begin
                  w_nextState = WR_WAIT;
                  w_nextCnt   = WL_LOAD;
               end
            end
         end
         WR_WAIT: begin
            if (r_cnt == 4'd0) begin
               w_nextState = WR_PRE;
            end else begin
               w_nextCnt = r_cnt - 4'd1;
            end
         end
         WR_PRE:   w_nextState = WR_BEAT0;
         WR_BEAT0: w_nextState = WR_BEAT1;
         WR_BEAT1: w_nextState = WR_POST;
         WR_POST:  w_nextState = IDLE;
         RD_WAIT: begin
            if (r_cnt == 4'd0) begin
               w_nextState = RD_CAP0;
            end else begin
               w_nextCnt = r_cnt - 4'd1;
            end
         end
         RD_CAP0:  w_nextState = RD_CAP1;
         RD_CAP1:  w_nextState = IDLE;
         default:  w_nextState = IDLE;
      endcase
   end

   // Bank-side outputs are registered from the next state so they line up with the state they belong to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrData  <= '0;
         r_wrAck   <= 1'b0;
         r_rdAck   <= 1'b0;
         r_bankT   <= 1'b1;
         r_bankD0  <= '0;
         r_bankD1  <= '0;
         r_rdValid <= 1'b0;
         r_rdData  <= '0;
      end else begin
         r_wrAck <= w_acceptWr;
         r_rdAck <= w_acceptRd;
         if (w_acceptWr) begin
            r_wrData <= wr_data;
         end
         r_bankT <= !(w_nextState == WR_PRE || w_nextState == WR_BEAT0 ||
                      w_nextState == WR_BEAT1 || w_nextState == WR_POST);
         case (w_nextState)
            WR_BEAT0: begin
               r_bankD0 <= r_wrData[BANK_WIDTH-1:0];
               r_bankD1 <= r_wrData[2*BANK_WIDTH-1:BANK_WIDTH];
            end
            WR_BEAT1: begin
               r_bankD0 <= r_wrData[3*BANK_WIDTH-1:2*BANK_WIDTH];
               r_bankD1 <= r_wrData[4*BANK_WIDTH-1:3*BANK_WIDTH];
            end
            default: begin
               r_bankD0 <= '0;
               r_bankD1 <= '0;
            end
         endcase
         if (r_state == RD_CAP0 || r_state == RD_CAP1) begin
            r_rdValid <= 1'b1;
            r_rdData  <= {bank_o1, bank_o0};
         end else begin
            r_rdValid <= 1'b0;
         end
      end
   end

   assign wr_ack   = r_wrAck;
   assign rd_ack   = r_rdAck;
   assign rd_valid = r_rdValid;
   assign rd_data  = r_rdData;
   assign bank_t   = r_bankT;
   assign bank_d0  = r_bankD0;
   assign bank_d1  = r_bankD1;
   assign busy     = (r_state != IDLE);

endmodule
